// File: rtl/lutram_rd_pkg.sv
// lutram_rd_pkg: shared types and sizing for the LUT RAM burst reader.
package lutram_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int FIFO_DEPTH = 2;
    // Wide enough for FIFO occupancy plus one in-flight read.
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);
endpackage

// File: rtl/lutram_rd_skid_fifo.sv
// lutram_rd_skid_fifo: two-entry output FIFO with a registered head entry.
import lutram_rd_pkg::*;

module lutram_rd_skid_fifo #(
    parameter int W = 73
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, slot;

    always_comb begin
        slot   = cnt_q - CNT_W'(pop_i);
        cnt_d  = slot + CNT_W'(push_i);
        head_d = (push_i && slot == '0) ? din_i :
                 (pop_i && cnt_q == CNT_W'(2)) ? tail_q : head_q;
        tail_d = (push_i && slot == CNT_W'(1)) ? din_i : tail_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/lutram_burst_reader.sv
// lutram_burst_reader: streams a (base, length) burst out of a LUT RAM with 1-cycle read latency.
import lutram_rd_pkg::*;

module lutram_burst_reader #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_base,
    input  logic [ADDR:0]   cmd_len,
    output logic [ADDR-1:0] mem_addr,
    input  logic [DATA-1:0] mem_dout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            out_last,
    output logic            busy
);
    state_t state_q;
    logic [ADDR-1:0] addr_q;
    logic [ADDR:0] rem_q;
    logic infl_q, infl_last_q;
    logic [CNT_W-1:0] cnt;
    logic [DATA:0] head;
    logic beat, issue, drained;

    assign beat = out_valid & out_ready;
    // A read may only launch if its word is guaranteed a FIFO slot when it lands.
    assign issue = state_q == RUN && rem_q != '0 &&
                   (cnt + CNT_W'(infl_q) < CNT_W'(FIFO_DEPTH) || beat);
    assign drained = !infl_q && (cnt == '0 || (cnt == CNT_W'(1) && beat));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= issue && rem_q == (ADDR+1)'(1);
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q <= cmd_base;
                    rem_q  <= cmd_len;
                    if (cmd_len != '0) state_q <= RUN;
                end
                RUN: if (issue) begin
                    addr_q <= addr_q + ADDR'(1);
                    rem_q  <= rem_q - (ADDR+1)'(1);
                    if (rem_q == (ADDR+1)'(1)) state_q <= DRAIN;
                end
                DRAIN: if (drained) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    lutram_rd_skid_fifo #(.W(DATA + 1)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (infl_q),
        .din_i  ({infl_last_q, mem_dout}),
        .pop_i  (beat),
        .head_o (head),
        .count_o(cnt)
    );

    assign cmd_ready = state_q == IDLE && !reset;
    assign mem_addr  = state_q == RUN ? addr_q : '0;
    assign out_valid = cnt != '0;
    assign out_data  = head[DATA-1:0];
    assign out_last  = out_valid & head[DATA];
    assign busy      = state_q != IDLE || cnt != '0;
endmodule

// File: tb/tb_lutram_burst_reader.sv
// tb_lutram_burst_reader: scoreboard bench with a mem[i]=i registered-read RAM model.
module tb_lutram_burst_reader;
    localparam int DATA = 72;
    localparam int ADDR = 10;

    logic clk = 0, reset = 1, cmd_valid = 0, out_ready = 1;
    logic [ADDR-1:0] cmd_base = '0, mem_addr;
    logic [ADDR:0] cmd_len = '0;
    logic [DATA-1:0] mem_dout = '0, out_data;
    logic cmd_ready, out_valid, out_last, busy;

    int n_chk = 0, n_bad = 0, n_last = 0, mode = 0;
    logic [DATA:0] exp_q[$];

    lutram_burst_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_dout <= DATA'(mem_addr);

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // out_ready pattern: 0 high, 1 toggle, 2 random, 3 low
    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            1: out_ready = !out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            3: out_ready = 0;
            default: out_ready = 1;
        endcase
    end

    initial begin
        logic pv = 0, pr = 0, plb = 0;
        logic [DATA-1:0] pd = '0;
        logic [DATA:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0;
                plb = 0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, pd);
                end
                if (plb) check("busy_after_last", busy, 0);
                plb = 0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("extra_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("data", out_data, e[DATA-1:0]);
                        check("last", out_last, e[DATA]);
                    end
                    if (out_last) begin
                        n_last++;
                        plb = 1;
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
            end
        end
    end

    task automatic send(input int base, input int len);
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1;
        cmd_base = ADDR'(base);
        cmd_len = (ADDR+1)'(len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'(i == len - 1), DATA'((base + i) % (1 << ADDR))});
        @(posedge clk);
        #1;
        cmd_valid = 0;
        check("busy_start", busy, len != 0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout", k >= budget, 0);
        check("leftover", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_last", out_last, 0);
        reset = 0;
        @(posedge clk);
        #1;

        send(5, 4);
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) check("first_addr", mem_addr, 5);
            check("t1_valid", out_valid, c >= 3 && c <= 6);
            check("t1_last", out_last, c == 6);
            @(posedge clk);
            #1;
        end
        wait_done(50);

        send(1023, 3);
        wait_done(50);

        mode = 1;
        send(0, 8);
        repeat (4) begin @(posedge clk); #1; end
        mode = 3;
        repeat (5) begin @(posedge clk); #1; end
        mode = 0;
        wait_done(100);

        send(7, 0);
        check("len0_ready", cmd_ready, 1);
        repeat (3) begin
            check("len0_valid", out_valid, 0);
            check("len0_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        send(0, 16);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        exp_q.delete();
        send(100, 2);
        wait_done(50);

        n_last = 0;
        mode = 2;
        send(0, 1024);
        wait_done(6000);
        check("single_last", n_last, 1);
        mode = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
